// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator (8x8, signed/unsigned): five 16-bit words summing to a*b mod 2^16.
// Latency 2 cycles (S1 digit encode, S2 pp select); full valid/ready backpressure, in_ready combinational from out_ready.
module booth_pp_gen (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   input  logic [7:0]  io_in_a,
   input  logic [7:0]  io_in_b,
   input  logic        io_in_signed,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [15:0] io_out_pp_0,
   output logic [15:0] io_out_pp_1,
   output logic [15:0] io_out_pp_2,
   output logic [15:0] io_out_pp_3,
   output logic [15:0] io_out_pp_4,
   output logic        io_out_signed
);

   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_dig_t;

   logic                s1_valid;
   logic                s2_valid;
   logic                s1_adv;
   logic                s2_adv;
   logic                in_fire;
   logic [15:0]         s1_a;
   logic                s1_signed;
   booth_dig_t [4:0]    s1_dig;
   booth_dig_t [4:0]    dig_nxt;
   logic [15:0]         a_ext;
   logic [10:0]         b_pad;
   logic [15:0]         mag     [5];
   logic [15:0]         sel     [5];
   logic [15:0]         pp_nxt  [5];
   logic [15:0]         pp_q    [5];
   logic                s2_signed;

   assign s2_adv      = !s2_valid || io_out_ready;
   assign s1_adv      = s1_valid && s2_adv;
   assign io_in_ready = !s1_valid || s2_adv;
   assign in_fire     = io_in_valid && io_in_ready;

   // b_pad = {B_ext, b[-1]}; digit i looks at the triplet b_pad[2i+2:2i]
   assign a_ext = {{8{io_in_signed & io_in_a[7]}}, io_in_a};
   assign b_pad = {{2{io_in_signed & io_in_b[7]}}, io_in_b, 1'b0};

   always_comb begin
      dig_nxt = '0;
      for (int i = 0; i < 5; i++) begin
         dig_nxt[i].neg = b_pad[2*i+2] & ~(b_pad[2*i+1] & b_pad[2*i]);
         dig_nxt[i].one = b_pad[2*i+1] ^ b_pad[2*i];
         dig_nxt[i].two = (b_pad[2*i+2] & ~b_pad[2*i+1] & ~b_pad[2*i]) |
                          (~b_pad[2*i+2] & b_pad[2*i+1] & b_pad[2*i]);
      end
   end

   // Full two's-complement negation here, so the tree needs no correction bits
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         mag[i]    = 16'd0;
         sel[i]    = 16'd0;
         pp_nxt[i] = 16'd0;
         if (s1_dig[i].two)
            mag[i] = {s1_a[14:0], 1'b0};
         else if (s1_dig[i].one)
            mag[i] = s1_a;
         sel[i]    = s1_dig[i].neg ? (~mag[i] + 16'd1) : mag[i];
         pp_nxt[i] = sel[i] << (2*i);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_a      <= 16'd0;
         s1_signed <= 1'b0;
         s1_dig    <= '0;
      end else begin
         if (io_in_ready)
            s1_valid <= io_in_valid;
         if (in_fire) begin
            s1_a      <= a_ext;
            s1_signed <= io_in_signed;
            s1_dig    <= dig_nxt;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s2_valid  <= 1'b0;
         s2_signed <= 1'b0;
         for (int i = 0; i < 5; i++)
            pp_q[i] <= 16'd0;
      end else begin
         if (s2_adv)
            s2_valid <= s1_valid;
         if (s1_adv) begin
            s2_signed <= s1_signed;
            for (int i = 0; i < 5; i++)
               pp_q[i] <= pp_nxt[i];
         end
      end
   end

   assign io_out_valid  = s2_valid;
   assign io_out_signed = s2_signed;
   assign io_out_pp_0   = pp_q[0];
   assign io_out_pp_1   = pp_q[1];
   assign io_out_pp_2   = pp_q[2];
   assign io_out_pp_3   = pp_q[3];
   assign io_out_pp_4   = pp_q[4];

endmodule

// File: tb/tb_booth_pp_gen.sv
// Bench for booth_pp_gen: scoreboard of expected partial products, tree sum and latency.
module tb_booth_pp_gen;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_in_valid;
   logic        io_in_ready;
   logic [7:0]  io_in_a;
   logic [7:0]  io_in_b;
   logic        io_in_signed;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [15:0] io_out_pp_0, io_out_pp_1, io_out_pp_2, io_out_pp_3, io_out_pp_4;
   logic        io_out_signed;

   booth_pp_gen dut (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (io_in_valid),
      .io_in_ready  (io_in_ready),
      .io_in_a      (io_in_a),
      .io_in_b      (io_in_b),
      .io_in_signed (io_in_signed),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_pp_0  (io_out_pp_0),
      .io_out_pp_1  (io_out_pp_1),
      .io_out_pp_2  (io_out_pp_2),
      .io_out_pp_3  (io_out_pp_3),
      .io_out_pp_4  (io_out_pp_4),
      .io_out_signed(io_out_signed)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [79:0] pp;
      logic        sgn;
      logic [15:0] prod;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;
   bit   lat_mode = 0;
   int   n_lat_out = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [79:0] model_pp(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic [79:0] r;
      logic [10:0] bp;
      int ae, d, p;
      ae = s ? int'({{24{a[7]}}, a}) : int'({24'd0, a});
      bp = {{2{s & b[7]}}, b, 1'b0};
      r  = '0;
      for (int i = 0; i < 5; i++) begin
         d = -2 * int'(bp[2*i+2]) + int'(bp[2*i+1]) + int'(bp[2*i]);
         p = (d * ae) << (2*i);
         r[16*i +: 16] = p[15:0];
      end
      return r;
   endfunction

   function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
      int ae, be, p;
      ae = s ? int'({{24{a[7]}}, a}) : int'({24'd0, a});
      be = s ? int'({{24{b[7]}}, b}) : int'({24'd0, b});
      p  = ae * be;
      return p[15:0];
   endfunction

   function automatic logic [15:0] tree_sum(input logic [79:0] v);
      logic [15:0] s;
      s = 16'd0;
      for (int i = 0; i < 5; i++)
         s = s + v[16*i +: 16];
      return s;
   endfunction

   function automatic logic [79:0] out_vec();
      return {io_out_pp_4, io_out_pp_3, io_out_pp_2, io_out_pp_1, io_out_pp_0};
   endfunction

   // Monitor: sample half a cycle from the edge; handshakes seen here complete on the next rising edge
   always @(negedge clock) begin
      if (reset) begin
         q.delete();
      end else begin
         if (io_out_valid && io_out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 96'd1, 96'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("pp", {16'd0, out_vec()}, {16'd0, e.pp});
               chk("sgn", {95'd0, io_out_signed}, {95'd0, e.sgn});
               chk("tree", {80'd0, tree_sum(out_vec())}, {80'd0, e.prod});
               if (lat_mode) begin
                  chk("latency", 96'(cyc - e.cyc), 96'd2);
                  n_lat_out++;
               end
            end
         end
         if (io_in_valid && io_in_ready) begin
            exp_t n;
            n.pp   = model_pp(io_in_a, io_in_b, io_in_signed);
            n.sgn  = io_in_signed;
            n.prod = model_prod(io_in_a, io_in_b, io_in_signed);
            n.cyc  = cyc;
            q.push_back(n);
         end
      end
   end

   // Presents a pair and returns one cycle after the edge that accepted it
   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s);
      bit acc;
      io_in_a      = a;
      io_in_b      = b;
      io_in_signed = s;
      io_in_valid  = 1'b1;
      acc = 0;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clock);
         acc = io_in_ready;
         @(posedge clock);
         #1;
      end
      if (!acc)
         chk("accept_timeout", 96'd0, 96'd1);
   endtask

   task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [79:0] exp_pp, input logic [15:0] exp_sum);
      bit seen;
      io_out_ready = 1'b1;
      drive(a, b, s);
      io_in_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clock);
         if (io_out_valid) begin
            seen = 1;
            chk("dir_pp", {16'd0, out_vec()}, {16'd0, exp_pp});
            chk("dir_sum", {80'd0, tree_sum(out_vec())}, {80'd0, exp_sum});
         end
      end
      if (!seen)
         chk("dir_timeout", 96'd0, 96'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [79:0] held;
      bit          acc;
      int          sent;
      int          guard;

      reset        = 1'b1;
      io_in_valid  = 1'b0;
      io_in_a      = 8'd0;
      io_in_b      = 8'd0;
      io_in_signed = 1'b0;
      io_out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      @(negedge clock);
      chk("rst_out_valid", {95'd0, io_out_valid}, 96'd0);
      chk("rst_pp", {16'd0, out_vec()}, 96'd0);
      chk("rst_out_signed", {95'd0, io_out_signed}, 96'd0);
      chk("rst_in_ready", {95'd0, io_in_ready}, 96'd1);
      @(posedge clock);
      #1;

      directed(8'hFF, 8'hFF, 1'b0, {16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'hFF01}, 16'hFE01);
      directed(8'h80, 8'h80, 1'b1, {16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000}, 16'h4000);
      directed(8'h03, 8'hFF, 1'b1, {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFD}, 16'hFFFD);
      directed(8'h80, 8'h7F, 1'b1, model_pp(8'h80, 8'h7F, 1'b1), 16'hC080);

      // Backpressure: two pairs fill S1/S2, the third stalls
      io_out_ready = 1'b0;
      drive(8'h12, 8'h34, 1'b0);
      drive(8'hA5, 8'h5A, 1'b1);
      io_in_a      = 8'h7F;
      io_in_b      = 8'h81;
      io_in_signed = 1'b1;
      io_in_valid  = 1'b1;
      @(negedge clock);
      chk("bp_in_ready_low", {95'd0, io_in_ready}, 96'd0);
      chk("bp_out_valid", {95'd0, io_out_valid}, 96'd1);
      held = out_vec();
      repeat (3) @(negedge clock);
      chk("bp_hold_pp", {16'd0, out_vec()}, {16'd0, held});
      chk("bp_in_ready_still_low", {95'd0, io_in_ready}, 96'd0);
      @(posedge clock);
      #1 io_out_ready = 1'b1;
      @(negedge clock);
      chk("bp_drain0_valid", {95'd0, io_out_valid}, 96'd1);
      chk("bp_in_ready_back", {95'd0, io_in_ready}, 96'd1);
      @(posedge clock);
      #1 io_in_valid = 1'b0;
      @(negedge clock);
      chk("bp_drain1_valid", {95'd0, io_out_valid}, 96'd1);
      @(negedge clock);
      chk("bp_drain2_valid", {95'd0, io_out_valid}, 96'd1);
      @(negedge clock);
      chk("bp_empty", {95'd0, io_out_valid}, 96'd0);
      chk("bp_queue_empty", 96'(q.size()), 96'd0);
      @(posedge clock);
      #1;

      // Reset with both stages full: flushed results must never surface
      io_out_ready = 1'b0;
      drive(8'h11, 8'h22, 1'b0);
      drive(8'h33, 8'h44, 1'b1);
      io_in_valid = 1'b0;
      reset       = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("mrst_out_valid", {95'd0, io_out_valid}, 96'd0);
      chk("mrst_pp", {16'd0, out_vec()}, 96'd0);
      chk("mrst_in_ready", {95'd0, io_in_ready}, 96'd1);
      @(posedge clock);
      #1 io_out_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1;

      // Streaming with out_ready tied high: one result per cycle, fixed latency
      lat_mode = 1;
      n_lat_out = 0;
      for (int k = 0; k < 50; k++) begin
         io_in_a      = 8'($urandom);
         io_in_b      = 8'($urandom);
         io_in_signed = 1'($urandom);
         io_in_valid  = 1'b1;
         @(posedge clock);
         #1;
      end
      io_in_valid = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      lat_mode = 0;
      chk("stream_count", 96'(n_lat_out), 96'd50);

      // Random traffic with random valid/ready
      sent  = 0;
      guard = 0;
      acc   = 1;
      while (sent < 10000 && guard < 60000) begin
         io_out_ready = ($urandom_range(0, 3) != 0);
         if (!io_in_valid || acc) begin
            if ($urandom_range(0, 3) != 0) begin
               io_in_a      = 8'($urandom);
               io_in_b      = 8'($urandom);
               io_in_signed = 1'($urandom);
               io_in_valid  = 1'b1;
            end else begin
               io_in_valid = 1'b0;
            end
         end
         @(negedge clock);
         acc = io_in_valid && io_in_ready;
         if (acc) sent++;
         @(posedge clock);
         #1;
         guard++;
      end
      io_in_valid  = 1'b0;
      io_out_ready = 1'b1;
      for (int k = 0; k < 20 && q.size() != 0; k++) begin
         @(posedge clock);
         #1;
      end
      chk("random_sent", 96'(sent), 96'd10000);
      chk("random_drained", 96'(q.size()), 96'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/booth_pp_gen.md
# booth_pp_gen

Pipelined radix-4 Booth partial-product generator for 8x8-bit multiplication, signed or unsigned per transaction. It emits five 16-bit partial products per accepted operand pair, and they feed the five data inputs of the 5-operand CSA/RCA compressor tree. The tree returns the 16-bit product as the mod-2^16 sum of the five words. The block is a two-stage valid/ready pipeline with full backpressure and a throughput of one operand pair per cycle.

## Interface
- Parameters: none. Widths are fixed: 8-bit operands, five 16-bit partial products, matching the 16-bit 5-input tree.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- io_in_valid  in  1  operand pair valid
- io_in_ready  out  1  block accepts the pair this cycle
- io_in_a  in  8  multiplicand
- io_in_b  in  8  multiplier
- io_in_signed  in  1  1 = both operands two's complement; 0 = both unsigned
- io_out_valid  out  1  partial products valid
- io_out_ready  in  1  consumer takes the partial products this cycle
- io_out_pp_0 .. io_out_pp_4  out  16 each  partial products, digit 0..4
- io_out_signed  out  1  mode of the transaction on the outputs

## Operation
- Operand extension:
  - A_ext is io_in_a extended to 16 bits: sign-extended if signed, zero-extended otherwise.
  - B_ext is io_in_b extended to 10 bits in the same way, with b[-1] = 0.
- Booth digits, i = 0..4: d_i = -2*B_ext[2i+1] + B_ext[2i] + B_ext[2i-1], so d_i is in {-2..+2}.
- Stage 1 (S1):
  - On acceptance, register A_ext, the mode, and each digit encoded as {neg, one, two}.
  - One-hot rule: one = (d_i = ±1), two = (d_i = ±2), neg = (d_i < 0). d_i = 0 encodes as all-zero, with neg = 0.
- Stage 2 (S2): register pp_i = (d_i * A_ext) << 2i, truncated to 16 bits.
  - Negation is exact two's complement (invert plus 1, folded in here), so no separate correction bits exist.
  - Required invariant: (pp_0 + ... + pp_4) mod 2^16 = a*b, interpreted in the selected mode.
  - In signed mode d_4 = 0 always, so pp_4 = 0. In unsigned mode d_4 = b[7].
- Handshake and flow control:
  - s2_adv = !s2_valid || io_out_ready
  - s1_adv = s1_valid && s2_adv
  - io_in_ready = !s1_valid || s2_adv. This is combinational from io_out_ready, by design.
  - Transfer happens on valid && ready at the rising edge. Transactions stay in order; none is dropped or duplicated.
- Stall: data registers load only on their stage's advance. While io_out_valid && !io_out_ready, io_out_pp_* and io_out_signed hold stable.
- Simultaneous events:
  - Full pipe with io_out_ready = 1 and io_in_valid = 1: S2 drains, S1 moves to S2, and the new pair enters S1 in the same cycle.
  - Empty pipe: io_in_ready = 1.
- Reset: synchronous, with priority over all handshakes.
  - Clears s1_valid, s2_valid, all digit registers, all pp registers and the mode registers to 0.
  - In-flight transactions are discarded and never appear at the output.

## Timing
- Latency: a pair accepted at edge N is presented with io_out_valid = 1 in the cycle after edge N+1, i.e. two registered stages.
- Throughput: one pair per cycle while io_out_ready = 1.
- Buffering: maximum two transactions held (S1 + S2). With io_out_ready held low, io_in_ready drops once both stages are valid.
- Outputs are driven directly from S2 registers. No combinational path runs from io_in_* to io_out_*.
- Reset values: io_out_valid = 0, io_out_pp_0..4 = 0x0000, io_out_signed = 0, io_in_ready = 1 (from the cycle after reset is sampled high).

## Test plan
- Unsigned a=0xFF, b=0xFF -> pp_0=0xFF01, pp_1..3=0x0000, pp_4=0xFF00; sum mod 2^16 = 0xFE01.
- Signed a=0x80, b=0x80 -> pp_3=0x4000, all other pp=0x0000; sum = 0x4000 (+16384).
- Signed a=0x03, b=0xFF -> pp_0=0xFFFD, others 0x0000; sum = 0xFFFD (-3).
- Backpressure:
  - Stimulus: present 3 back-to-back pairs with io_out_ready=0 from the first output cycle.
  - Required: io_in_ready=0 once S1 and S2 are both valid; the third pair stalls; outputs hold stable.
  - After io_out_ready=1: the three results emerge in order on consecutive cycles, with no loss or duplicate.
- Reset mid-operation: with both stages valid, assert reset for 1 cycle -> next cycle io_out_valid=0, all pp=0x0000, io_in_ready=1; flushed results never appear.
- Random end-to-end:
  - Stimulus: 10k random pairs with random mode and random io_in_valid/io_out_ready; outputs drive the 5-input compressor tree.
  - Required: tree output equals a*b mod 2^16 per mode for every transaction.
  - Required: with io_out_ready tied to 1, one result per cycle and a 2-cycle latency.
